lpf_iir1_mc: RTL and testbench

LPF_IIR1_MC -- requirements
Module: lpf_iir1_mc

---
 rtl/lpf_iir1_mc.sv | 104 ++++++++++
 tb/tb_lpf_iir1_mc.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lpf_iir1_mc.sv
// Time-multiplexed first-order IIR low-pass filter, NCH independent channels, 1-cycle latency.
// Optional high-pass output out_hp (in - low-pass, saturated) when LPF_HP_EN is defined.
module lpf_iir1_mc #(
  parameter int W   = 10,
  parameter int K   = 3,
  parameter int NCH = 4,
  parameter int CHW = 2
) (
  input  logic                 clk60kHz,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [CHW-1:0]       in_ch,
  input  logic signed [W-1:0]  in,
  input  logic                 flush,
  output logic                 out_valid,
  output logic [CHW-1:0]       out_ch,
  output logic signed [W-1:0]  out,
  output logic                 out_settled
`ifdef LPF_HP_EN
  ,
  output logic signed [W-1:0]  out_hp
`endif
);

  localparam int          AW      = W + K + 2;
  localparam int unsigned DEPTH   = 1 << CHW;
  localparam logic [K+2:0] CNT_MAX = {1'b1, {(K+2){1'b0}}};
  localparam logic [CHW:0] NCH_LIM = (CHW+1)'(NCH);

  logic signed [AW-1:0] acc [DEPTH];
  logic signed [W-1:0]  x1  [DEPTH];
  logic [K+2:0]         cnt [DEPTH];

  logic signed [AW-1:0] acc_cur, acc_new, in_ext, x1_ext, acc_shr;
  logic signed [W-1:0]  x1_cur, lp_new;
  logic [K+2:0]         cnt_cur, cnt_next;
  logic                 settled_new, accept;

  always_comb begin
    accept      = in_valid && !flush && ({1'b0, in_ch} < NCH_LIM);
    acc_cur     = acc[in_ch];
    x1_cur      = x1[in_ch];
    cnt_cur     = cnt[in_ch];
    // Each term is widened on its own so the shift stays arithmetic.
    in_ext      = signed'({{(K+2){in[W-1]}}, in});
    x1_ext      = signed'({{(K+2){x1_cur[W-1]}}, x1_cur});
    acc_shr     = acc_cur >>> K;
    acc_new     = acc_cur + in_ext + x1_ext - acc_shr;
    lp_new      = acc_new[K+1 +: W];
    settled_new = (cnt_cur == CNT_MAX);
    cnt_next    = settled_new ? cnt_cur : cnt_cur + {{(K+2){1'b0}}, 1'b1};
  end

`ifdef LPF_HP_EN
  logic [W:0]          hp_wide;
  logic signed [W-1:0] hp_new;

  always_comb begin
    hp_wide = {in[W-1], in} - {lp_new[W-1], lp_new};
    if (hp_wide[W] != hp_wide[W-1])
      hp_new = hp_wide[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    else
      hp_new = hp_wide[W-1:0];
  end
`endif

  always_ff @(posedge clk60kHz or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        acc[i] <= '0;
        x1[i]  <= '0;
        cnt[i] <= '0;
      end
      out_valid   <= 1'b0;
      out_ch      <= '0;
      out         <= '0;
      out_settled <= 1'b0;
`ifdef LPF_HP_EN
      out_hp      <= '0;
`endif
    end else if (flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        acc[i] <= '0;
        x1[i]  <= '0;
        cnt[i] <= '0;
      end
      out_valid <= 1'b0;
    end else begin
      out_valid <= accept;
      if (accept) begin
        acc[in_ch]  <= acc_new;
        x1[in_ch]   <= in;
        cnt[in_ch]  <= cnt_next;
        out_ch      <= in_ch;
        out         <= lp_new;
        out_settled <= settled_new;
`ifdef LPF_HP_EN
        out_hp      <= hp_new;
`endif
      end
    end
  end

endmodule

// File: tb/tb_lpf_iir1_mc.sv
// Scoreboard bench for lpf_iir1_mc: stimulus pushes model expectations, a monitor pops and compares.
module tb_lpf_iir1_mc;
  localparam int W   = 10;
  localparam int K   = 3;
  localparam int NCH = 4;
  localparam int CHW = 3;  // wide enough to present an out-of-range channel

  logic                clk60kHz = 1'b0;
  logic                rst = 1'b0;
  logic                in_valid = 1'b0;
  logic [CHW-1:0]      in_ch = '0;
  logic signed [W-1:0] in_s = '0;
  logic                flush = 1'b0;
  logic                out_valid;
  logic [CHW-1:0]      out_ch;
  logic signed [W-1:0] out;
  logic                out_settled;
`ifdef LPF_HP_EN
  logic signed [W-1:0] out_hp;
`endif

  lpf_iir1_mc #(.W(W), .K(K), .NCH(NCH), .CHW(CHW)) dut (
    .clk60kHz(clk60kHz),
    .rst(rst),
    .in_valid(in_valid),
    .in_ch(in_ch),
    .in(in_s),
    .flush(flush),
    .out_valid(out_valid),
    .out_ch(out_ch),
    .out(out),
    .out_settled(out_settled)
`ifdef LPF_HP_EN
    ,
    .out_hp(out_hp)
`endif
  );

  always #5 clk60kHz = ~clk60kHz;

  typedef struct {
    bit v;
    int ch;
    int lp;
    bit st;
    int hp;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference: y[n] from acc[n] = acc[n-1] + x[n] + x[n-1] - floor(acc[n-1]/2^K), y = floor(acc/2^(K+1)).
  longint m_acc [NCH];
  int     m_x1  [NCH];
  int     m_cnt [NCH];
  int     last_lp, last_ch, last_hp;

  function automatic int wrapw(longint v);
    logic signed [W-1:0] t;
    t = v[W-1:0];
    return int'(t);
  endfunction

  function automatic void model_clear(bit outputs_too);
    for (int i = 0; i < NCH; i++) begin
      m_acc[i] = 0;
      m_x1[i]  = 0;
      m_cnt[i] = 0;
    end
    if (outputs_too) begin
      last_lp = 0;
      last_ch = 0;
      last_hp = 0;
    end
  endfunction

  function automatic exp_t model_step(bit v, int ch, int x, bit fl);
    exp_t   e;
    longint a;
    int     lp, hp;
    e.v  = 0;
    e.st = 0;
    if (fl) begin
      model_clear(1'b0);
    end else if (v && ch < NCH) begin
      a = m_acc[ch] + x + m_x1[ch] - (m_acc[ch] >>> K);
      m_acc[ch] = a;
      m_x1[ch]  = x;
      lp = wrapw(a >>> (K + 1));
      hp = x - lp;
      if (hp > (1 << (W - 1)) - 1) hp = (1 << (W - 1)) - 1;
      if (hp < -(1 << (W - 1)))    hp = -(1 << (W - 1));
      e.st = (m_cnt[ch] == (1 << (K + 2)));
      if (m_cnt[ch] < (1 << (K + 2))) m_cnt[ch]++;
      last_lp = lp;
      last_ch = ch;
      last_hp = hp;
      e.v = 1;
    end
    e.ch = last_ch;
    e.lp = last_lp;
    e.hp = last_hp;
    return e;
  endfunction

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic step(bit v, int ch, int x, bit fl);
    @(negedge clk60kHz);
    in_valid = v;
    in_ch    = ch[CHW-1:0];
    in_s     = x[W-1:0];
    flush    = fl;
    q.push_back(model_step(v, ch, x, fl));
  endtask

  task automatic settle_probe();
    @(posedge clk60kHz);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk60kHz);
    in_valid = 1'b0;
    flush    = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out", int'(out), 0);
    chk("rst_out_ch", int'(out_ch), 0);
    chk("rst_out_settled", int'(out_settled), 0);
`ifdef LPF_HP_EN
    chk("rst_out_hp", int'(out_hp), 0);
`endif
    @(negedge clk60kHz);
    rst = 1'b0;
    model_clear(1'b1);
  endtask

  // Monitor: one expectation per driven cycle, checked just after the edge that registers it.
  always @(posedge clk60kHz) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("out_valid", int'(out_valid), int'(e.v));
      chk("out", int'(out), e.lp);
      chk("out_ch", int'(out_ch), e.ch);
      if (e.v) chk("out_settled", int'(out_settled), int'(e.st));
`ifdef LPF_HP_EN
      chk("out_hp", int'(out_hp), e.hp);
`endif
    end else if (!rst) begin
      chk("idle_out_valid", int'(out_valid), 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear(1'b1);
    do_reset();

    // Step response on ch0
    for (int i = 0; i < 80; i++) begin
      step(1, 0, 100, 0);
      if (i == 0)  begin settle_probe(); chk("step_y0", int'(out), 6);  end
      if (i == 1)  begin settle_probe(); chk("step_y1", int'(out), 18); end
      if (i == 2)  begin settle_probe(); chk("step_y2", int'(out), 28); end
      if (i == 31) begin settle_probe(); chk("settled_32", int'(out_settled), 0); end
      if (i == 32) begin settle_probe(); chk("settled_33", int'(out_settled), 1); end
      if (i == 79) begin settle_probe(); chk("step_final", int'(out), 100); end
    end
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // Negative step on ch1, other channels untouched
    do_reset();
    for (int i = 0; i < 80; i++) step(1, 1, -100, 0);
    settle_probe();
    chk("neg_final", int'(out), -100);
    step(1, 0, 0, 0); settle_probe(); chk("iso_ch0", int'(out), 0);
    step(1, 2, 0, 0); settle_probe(); chk("iso_ch2", int'(out), 0);
    step(1, 3, 0, 0); settle_probe(); chk("iso_ch3", int'(out), 0);

    // Round robin
    do_reset();
    for (int i = 0; i < 200; i++) begin
      step(1, 0, 100, 0);
      step(1, 1, -200, 0);
      step(1, 2, 0, 0);
      step(1, 3, 511, 0);
    end
    settle_probe();
    chk("rr_ch3_final", int'(out), 511);

    // Flush together with a sample
    step(1, 0, 100, 1);
    step(1, 0, 100, 0);
    settle_probe();
    chk("flush_y0", int'(out), 6);
    chk("flush_settled", int'(out_settled), 0);

    // Out-of-range channel then continuity on ch0
    step(1, 5, 300, 0);
    step(1, 7, -300, 0);
    step(1, 0, 100, 0);
    settle_probe();
    chk("badch_cont", int'(out), 18);

    // High-pass saturation: low-pass settled at -512, then a +511 sample
    for (int i = 0; i < 80; i++) step(1, 2, -512, 0);
    step(1, 2, 511, 0);
`ifdef LPF_HP_EN
    settle_probe();
    chk("hp_sat", int'(out_hp), 511);
`endif

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      int  x;
      bit  v, fl;
      int  ch;
      v  = ($urandom_range(0, 3) != 0);
      ch = $urandom_range(0, 5);
      x  = int'($urandom_range(0, 1023)) - 512;
      fl = ($urandom_range(0, 63) == 0);
      step(v, ch, x, fl);
    end

    // Mid-stream asynchronous reset
    step(1, 3, 400, 0);
    do_reset();
    step(1, 3, 100, 0);
    settle_probe();
    chk("post_rst_y0", int'(out), 6);

    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    settle_probe();
    chk("queue_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
